// File: rtl/clk_gen_pkg.sv
// Shared constants and types for the programmable clock/tick generator.
// Period constants assume the 40 MHz board clock.
package clk_gen_pkg;

  localparam int CNT_W_DEF = 26;

  localparam int PER_1US   = 40;
  localparam int PER_500MS = 20_000_000;
  localparam int PER_1S    = 40_000_000;
  localparam int PER_LCD   = 512;
  localparam int PER_7SEG  = 65536;

  localparam int DEF_PER_1US = PER_1US;
  localparam int DEF_LOW_1US = PER_1US / 2;

  // What a channel does at the coming edge, in priority order STOP > RESTART > WRAP > COUNT.
  typedef enum logic [1:0] {
    EVT_COUNT   = 2'd0,
    EVT_WRAP    = 2'd1,
    EVT_RESTART = 2'd2,
    EVT_STOP    = 2'd3
  } ch_evt_e;

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: period counter, shadow/active period and duty registers,
// and registered clock/tick outputs. Settings only move shadow->active at a period boundary.
module clk_div_ch
  import clk_gen_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DEF_PER = DEF_PER_1US,
  parameter int DEF_LOW = DEF_LOW_1US
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wr,
  input  logic             sync,
  input  logic [CNT_W-1:0] cfg_per,
  input  logic [CNT_W-1:0] cfg_low,
  output logic             clk_out,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] act_per_q, act_per_d;
  logic [CNT_W-1:0] act_low_q, act_low_d;
  logic [CNT_W-1:0] shd_per_q, shd_per_d;
  logic [CNT_W-1:0] shd_low_q, shd_low_d;
  logic             pend_q, pend_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;

  logic [CNT_W-1:0] per_eff;
  logic             wrap;
  ch_evt_e          evt;

  // Periods below 2 cannot toggle, so they are clamped.
  function automatic logic [CNT_W-1:0] eff_period(input logic [CNT_W-1:0] per);
    return (per < CNT_W'(2)) ? CNT_W'(2) : per;
  endfunction

  always_comb begin
    per_eff = eff_period(act_per_q);
    wrap    = (cnt_q == per_eff - CNT_W'(1));
    if (!en)       evt = EVT_STOP;
    else if (sync) evt = EVT_RESTART;
    else if (wrap) evt = EVT_WRAP;
    else           evt = EVT_COUNT;
  end

  always_comb begin
    cnt_d     = cnt_q;
    act_per_d = act_per_q;
    act_low_d = act_low_q;
    shd_per_d = shd_per_q;
    shd_low_d = shd_low_q;
    pend_d    = pend_q;
    clk_out_d = 1'b0;
    tick_d    = 1'b0;

    case (evt)
      EVT_STOP, EVT_RESTART: begin
        cnt_d = '0;
        if (pend_q) begin
          act_per_d = shd_per_q;
          act_low_d = shd_low_q;
          pend_d    = 1'b0;
        end
      end
      EVT_WRAP: begin
        cnt_d     = '0;
        clk_out_d = (cnt_q >= act_low_q);
        tick_d    = 1'b1;
        if (pend_q) begin
          act_per_d = shd_per_q;
          act_low_d = shd_low_q;
          pend_d    = 1'b0;
        end
      end
      default: begin
        cnt_d     = cnt_q + CNT_W'(1);
        clk_out_d = (cnt_q >= act_low_q);
      end
    endcase

    // A write landing on the wrap edge bypasses the shadow and takes effect now.
    if (wr) begin
      shd_per_d = cfg_per;
      shd_low_d = cfg_low;
      if (evt == EVT_WRAP) begin
        act_per_d = cfg_per;
        act_low_d = cfg_low;
        pend_d    = 1'b0;
      end else begin
        pend_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      act_per_q <= CNT_W'(DEF_PER);
      act_low_q <= CNT_W'(DEF_LOW);
      shd_per_q <= CNT_W'(DEF_PER);
      shd_low_q <= CNT_W'(DEF_LOW);
      pend_q    <= 1'b0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      act_per_q <= act_per_d;
      act_low_q <= act_low_d;
      shd_per_q <= shd_per_d;
      shd_low_q <= shd_low_d;
      pend_q    <= pend_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;

endmodule

// File: rtl/prog_clk_gen.sv
// N-channel programmable clock/tick generator: independent divider channels
// sharing one configuration bus and a common phase-restart input.
module prog_clk_gen
  import clk_gen_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DEF_PER = DEF_PER_1US,
  parameter int DEF_LOW = DEF_LOW_1US
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  ch_en,
  input  logic [N_CH-1:0]  cfg_wr,
  input  logic [CNT_W-1:0] cfg_per,
  input  logic [CNT_W-1:0] cfg_low,
  input  logic             sync,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  tick
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    clk_div_ch #(
      .CNT_W   (CNT_W),
      .DEF_PER (DEF_PER),
      .DEF_LOW (DEF_LOW)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (ch_en[i]),
      .wr      (cfg_wr[i]),
      .sync    (sync),
      .cfg_per (cfg_per),
      .cfg_low (cfg_low),
      .clk_out (clk_out[i]),
      .tick    (tick[i])
    );
  end

endmodule

// File: tb/tb_prog_clk_gen.sv
// Self-checking bench for prog_clk_gen: directed scenarios with closed-form
// waveform expectations, plus randomized traffic against a behavioural model.
module tb_prog_clk_gen;
  localparam int N = 4;
  localparam int W = 26;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] ch_en, cfg_wr;
  logic [W-1:0] cfg_per, cfg_low;
  logic         sync;
  logic [N-1:0] clk_out, tick;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prog_clk_gen #(.N_CH(N), .CNT_W(W), .DEF_PER(40), .DEF_LOW(20)) dut (
    .clk(clk), .rst(rst), .ch_en(ch_en), .cfg_wr(cfg_wr), .cfg_per(cfg_per),
    .cfg_low(cfg_low), .sync(sync), .clk_out(clk_out), .tick(tick)
  );

  // Behavioural model: position within the current period plus settings.
  int           m_cnt[N], m_per[N], m_low[N], m_sper[N], m_slow[N];
  bit           m_pend[N];
  logic [N-1:0] m_clk, m_tick;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0; m_per[i] = 40; m_low[i] = 20;
      m_sper[i] = 40; m_slow[i] = 20; m_pend[i] = 0;
    end
    m_clk = '0; m_tick = '0;
  endtask

  task automatic model_step();
    for (int i = 0; i < N; i++) begin
      int p;
      bit run, bnd;
      p   = (m_per[i] < 2) ? 2 : m_per[i];
      run = ch_en[i] && !sync;
      bnd = run ? (m_cnt[i] + 1 == p) : 1'b1;
      m_tick[i] = run && bnd;
      m_clk[i]  = run && (m_cnt[i] >= m_low[i]);
      m_cnt[i]  = bnd ? 0 : m_cnt[i] + 1;
      if (bnd && m_pend[i]) begin
        m_per[i] = m_sper[i]; m_low[i] = m_slow[i]; m_pend[i] = 0;
      end
      if (cfg_wr[i]) begin
        m_sper[i] = int'(cfg_per); m_slow[i] = int'(cfg_low);
        if (run && bnd) begin
          m_per[i] = int'(cfg_per); m_low[i] = int'(cfg_low); m_pend[i] = 0;
        end else begin
          m_pend[i] = 1;
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ch_en = '0; cfg_wr = '0; cfg_per = '0; cfg_low = '0; sync = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (clk_out !== 4'b0000 || tick !== 4'b0000) begin
      errors++; $display("FAIL reset_outputs clk_out=%b tick=%b expected 0000 0000", clk_out, tick);
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      checks++;
      if (clk_out !== m_clk || tick !== m_tick) begin
        errors++; $display("FAIL reset_idle clk_out=%b tick=%b expected %b %b", clk_out, tick, m_clk, m_tick);
      end
    end
  endtask

  task automatic test_default();
    ch_en = 4'b0001;
    for (int k = 1; k <= 100; k++) begin
      logic e_c, e_t;
      cyc();
      e_c = ((k - 1) % 40) >= 20;
      e_t = (k % 40) == 0;
      checks++;
      if (clk_out[0] !== e_c || tick[0] !== e_t || clk_out !== m_clk || tick !== m_tick) begin
        errors++; $display("FAIL default_wave k=%0d clk_out=%b tick=%b expected ch0 %b %b all %b %b",
                           k, clk_out, tick, e_c, e_t, m_clk, m_tick);
      end
    end
  endtask

  task automatic test_reconfig();
    for (int n = 0; n < 60 && m_cnt[0] != 5; n++) cyc();
    if (m_cnt[0] != 5) begin
      errors++; $display("FAIL reconfig_wait timeout cnt=%0d expected 5", m_cnt[0]);
    end
    cfg_wr = 4'b0001; cfg_per = W'(10); cfg_low = W'(3);
    cyc();
    cfg_wr = '0;
    for (int j = 1; j <= 34; j++) begin
      logic e_c, e_t;
      cyc();
      e_c = (5 + j) >= 20;
      e_t = (j == 34);
      checks++;
      if (clk_out[0] !== e_c || tick[0] !== e_t || clk_out !== m_clk || tick !== m_tick) begin
        errors++; $display("FAIL reconfig_old j=%0d clk_out=%b tick=%b expected ch0 %b %b", j, clk_out, tick, e_c, e_t);
      end
    end
    for (int j = 1; j <= 30; j++) begin
      logic e_c, e_t;
      cyc();
      e_c = ((j - 1) % 10) >= 3;
      e_t = (j % 10) == 0;
      checks++;
      if (clk_out[0] !== e_c || tick[0] !== e_t || clk_out !== m_clk || tick !== m_tick) begin
        errors++; $display("FAIL reconfig_new j=%0d clk_out=%b tick=%b expected ch0 %b %b", j, clk_out, tick, e_c, e_t);
      end
    end
  endtask

  task automatic test_clamp();
    int pl[2], ll[2];
    pl = '{1, 8}; ll = '{0, 8};
    for (int s = 0; s < 2; s++) begin
      int p;
      p = (pl[s] < 2) ? 2 : pl[s];
      ch_en[1] = 1'b0;
      cfg_wr = 4'b0010; cfg_per = W'(pl[s]); cfg_low = W'(ll[s]);
      cyc();
      cfg_wr = '0;
      cyc();
      ch_en[1] = 1'b1;
      for (int j = 1; j <= 24; j++) begin
        logic e_c, e_t;
        cyc();
        e_c = (s == 0);
        e_t = (j % p) == 0;
        checks++;
        if (clk_out[1] !== e_c || tick[1] !== e_t || clk_out !== m_clk || tick !== m_tick) begin
          errors++; $display("FAIL clamp_per%0d j=%0d clk_out=%b tick=%b expected ch1 %b %b",
                             pl[s], j, clk_out, tick, e_c, e_t);
        end
      end
    end
  endtask

  task automatic test_sync();
    int pl[N], ll[N];
    pl = '{40, 16, 7, 100}; ll = '{20, 5, 3, 60};
    ch_en = '0;
    for (int i = 0; i < N; i++) begin
      cfg_wr = 4'(1 << i); cfg_per = W'(pl[i]); cfg_low = W'(ll[i]);
      cyc();
    end
    cfg_wr = '0;
    cyc();
    ch_en = 4'b1111;
    repeat ($urandom_range(10, 60)) begin
      cyc();
      checks++;
      if (clk_out !== m_clk || tick !== m_tick) begin
        errors++; $display("FAIL sync_pre clk_out=%b tick=%b expected %b %b", clk_out, tick, m_clk, m_tick);
      end
    end
    sync = 1'b1;
    cyc();
    sync = 1'b0;
    checks++;
    if (clk_out !== 4'b0000 || tick !== 4'b0000) begin
      errors++; $display("FAIL sync_zero clk_out=%b tick=%b expected 0000 0000", clk_out, tick);
    end
    for (int j = 1; j <= 120; j++) begin
      logic [N-1:0] e_c, e_t;
      cyc();
      for (int i = 0; i < N; i++) begin
        e_c[i] = ((j - 1) % pl[i]) >= ll[i];
        e_t[i] = (j % pl[i]) == 0;
      end
      checks++;
      if (clk_out !== e_c || tick !== e_t || clk_out !== m_clk || tick !== m_tick) begin
        errors++; $display("FAIL sync_phase j=%0d clk_out=%b tick=%b expected %b %b", j, clk_out, tick, e_c, e_t);
      end
    end
  endtask

  task automatic test_wrap_write();
    for (int n = 0; n < 20 && m_cnt[2] != 6; n++) cyc();
    if (m_cnt[2] != 6) begin
      errors++; $display("FAIL wrap_wait timeout cnt=%0d expected 6", m_cnt[2]);
    end
    cfg_wr = 4'b0100; cfg_per = W'(6); cfg_low = W'(2);
    cyc();
    cfg_wr = '0;
    checks++;
    if (tick[2] !== 1'b1) begin
      errors++; $display("FAIL wrap_tick tick=%b expected ch2 1", tick);
    end
    for (int j = 1; j <= 24; j++) begin
      logic e_c, e_t;
      cyc();
      e_c = ((j - 1) % 6) >= 2;
      e_t = (j % 6) == 0;
      checks++;
      if (clk_out[2] !== e_c || tick[2] !== e_t || clk_out !== m_clk || tick !== m_tick) begin
        errors++; $display("FAIL wrap_new j=%0d clk_out=%b tick=%b expected ch2 %b %b", j, clk_out, tick, e_c, e_t);
      end
    end
    ch_en[2] = 1'b0;
    cfg_wr = 4'b0100; cfg_per = W'(9); cfg_low = W'(4);
    cyc();
    cfg_wr = '0;
    cyc();
    ch_en[2] = 1'b1;
    for (int j = 1; j <= 27; j++) begin
      logic e_c, e_t;
      cyc();
      e_c = ((j - 1) % 9) >= 4;
      e_t = (j % 9) == 0;
      checks++;
      if (clk_out[2] !== e_c || tick[2] !== e_t || clk_out !== m_clk || tick !== m_tick) begin
        errors++; $display("FAIL disabled_cfg j=%0d clk_out=%b tick=%b expected ch2 %b %b", j, clk_out, tick, e_c, e_t);
      end
    end
  endtask

  task automatic test_async_rst();
    ch_en = 4'b1111;
    repeat (13) cyc();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (clk_out !== 4'b0000 || tick !== 4'b0000) begin
      errors++; $display("FAIL async_rst clk_out=%b tick=%b expected 0000 0000", clk_out, tick);
    end
    model_reset();
    #2 rst = 1'b0;
    for (int j = 1; j <= 80; j++) begin
      logic e_c, e_t;
      cyc();
      e_c = ((j - 1) % 40) >= 20;
      e_t = (j % 40) == 0;
      checks++;
      if (clk_out !== {N{e_c}} || tick !== {N{e_t}} || clk_out !== m_clk || tick !== m_tick) begin
        errors++; $display("FAIL rst_defaults j=%0d clk_out=%b tick=%b expected all %b %b", j, clk_out, tick, e_c, e_t);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < N; i++) ch_en[i] = ($urandom_range(0, 15) != 0);
      cfg_wr  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      cfg_per = W'($urandom_range(0, 20));
      cfg_low = W'($urandom_range(0, 22));
      sync    = ($urandom_range(0, 63) == 0);
      cyc();
      checks++;
      if (clk_out !== m_clk || tick !== m_tick) begin
        errors++; $display("FAIL random k=%0d clk_out=%b tick=%b expected %b %b", k, clk_out, tick, m_clk, m_tick);
      end
    end
    cfg_wr = '0; sync = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_default();
    test_reconfig();
    test_clamp();
    test_sync();
    test_wrap_write();
    test_async_rst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
